// File: rtl/inst_fetch_stage.sv
// inst_fetch_stage
//   Owns the program counter, issues word fetches over a req/ready handshake,
//   and buffers returned words in a 2-entry queue whose head feeds IF/ID.
//   A taken branch from EX flushes the queue and redirects fetch. If a fetch
//   is in flight at that point, its returning word is dropped.
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   freeze                    stall from the hazard unit (head is not consumed)
//   branch_taken, branch_addr redirect from EX
//   imem_req/imem_addr        fetch request to instruction memory
//   imem_ready/imem_rdata     response strobe and fetched word
//   instruction_IF, pc_IF     queue head word and head address + 4 (0 when empty)
//   inst_valid                queue non-empty
module inst_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction_IF,
  output logic [31:0] pc_IF,
  output logic        inst_valid
);

  localparam logic [2:0] QD = 3'(QDEPTH);

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] addr;
  } qent_t;

  qent_t       q_mem [2];
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_addr_q;               // address of the fetch currently in flight
  logic        out_q, out_d;             // request issued, response not yet seen
  logic        disc_q, disc_d;           // in-flight response must be dropped
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        resp, push, pop;
  qent_t       head;

  // A new request starts only when a queue slot is guaranteed for its word;
  // an in-flight request (out_q) keeps req high until its response.
  always_comb begin
    imem_req  = rst & (out_q | ((3'(cnt_q) + 3'(out_q & ~disc_q)) < QD));
    // Hold the issued address while waiting, even if a branch moves fetch_pc.
    imem_addr = out_q ? req_addr_q : fetch_pc_q;
  end

  always_comb begin
    resp = imem_req & imem_ready;
    push = resp & ~disc_q & ~branch_taken;
    pop  = inst_valid & ~freeze & ~branch_taken;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    out_d      = imem_req & ~imem_ready;
    disc_d     = disc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    cnt_d      = cnt_q;
    if (branch_taken) begin
      fetch_pc_d = branch_addr;
      // Anything still in flight after this edge belongs to the old path.
      disc_d     = imem_req & ~imem_ready;
      rd_ptr_d   = 1'b0;
      wr_ptr_d   = 1'b0;
      cnt_d      = 2'd0;
    end else begin
      if (resp) disc_d = 1'b0;
      if (push) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        wr_ptr_d   = ~wr_ptr_q;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      cnt_d = cnt_q + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      out_q      <= 1'b0;
      disc_q     <= 1'b0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= imem_addr;
      out_q      <= out_d;
      disc_q     <= disc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  // Queue storage needs no reset; entries are only visible when counted.
  always_ff @(posedge clk) begin
    if (push) q_mem[wr_ptr_q] <= '{word: imem_rdata, addr: fetch_pc_q};
  end

  always_comb begin
    head           = q_mem[rd_ptr_q];
    inst_valid     = (cnt_q != 2'd0);
    instruction_IF = inst_valid ? head.word : 32'd0;
    pc_IF          = inst_valid ? head.addr + 32'd4 : 32'd0;
  end

endmodule
